pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning maximum consecutive MEM_WAIT cycles before fault (range 1..255).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 id_rs1, id_rs2  input  5 each  ID-stage source register indices.
REQ-005 id_uses_rs2  input  1  ID instruction reads rs2.
REQ-006 ex_rd  input  5  EX-stage destination index.
REQ-007 ex_memread  input  1  EX instruction is a load.
REQ-008 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-009 mem_req  input  1  MEM stage holds a load or store.
REQ-010 dmem_ack  input  1  data memory completes the MEM access this cycle.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  stage-register load enables.
REQ-012 ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble (all-zero control fields).
REQ-013 fault  output  1  sticky memory-timeout indication.
REQ-014 stall_cnt  output  16  saturating count of cycles with pc_en=0.

Function
REQ-015 FSM states RUN, MEM_WAIT, FAULT; the controller SHALL hold exactly one state at all times.
REQ-016 Load-use hazard = ex_memread & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
REQ-017 Memory stall = mem_req & ~dmem_ack.
REQ-018 RUN, no event: all enables 1, all flushes 0.
REQ-019 RUN, memory stall: all enables 0, memwb_flush=1, next state MEM_WAIT; overrides branch and load-use that cycle.
REQ-020 RUN, taken branch, no memory stall: all enables 1, ifid_flush=1, idex_flush=1; load-use ignored.
REQ-021 RUN, load-use only: pc_en=0, ifid_en=0, idex_flush=1, other enables 1; lasts one cycle by construction.
REQ-022 MEM_WAIT with dmem_ack=0: outputs as REQ-019; wait counter increments.
REQ-023 MEM_WAIT with dmem_ack=1: outputs evaluated per REQ-018/020/021; next state RUN; wait counter cleared.
REQ-024 Wait counter 8 bits, cleared on entry to MEM_WAIT; when it equals TIMEOUT with dmem_ack=0, next state FAULT.
REQ-025 FAULT: all enables 0, all flushes 0, fault=1; exit only by reset.
REQ-026 Outputs are combinational from state and inputs; no added latency.
REQ-027 stall_cnt increments on every clock edge where pc_en=0 and saturates at 16'hFFFF.

Reset
REQ-028 On rst: state RUN, wait counter 0, stall_cnt 0, fault 0, regardless of clock.
REQ-029 While rst=1, all enables and flushes SHALL be 0.
REQ-030 rst asserted during MEM_WAIT or FAULT SHALL return to RUN with no residual count.

Structure
REQ-031 State encoding and the TIMEOUT default SHALL reside in shared package pipe_ctrl_pkg.
REQ-032 Load-use comparison SHALL be a combinational sub-module hazard_detect.

Verification
REQ-033 ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1.
REQ-034 Same as REQ-033 with ex_rd=0 -> no stall, all enables 1.
REQ-035 mem_req=1, dmem_ack low 3 cycles then high -> MEM_WAIT 3 cycles with all enables 0 and memwb_flush=1, RUN on ack cycle, stall_cnt=4.
REQ-036 ex_branch_taken=1 with load-use true -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-037 TIMEOUT=4, dmem_ack never asserted -> FAULT after 5 stall cycles, fault=1 held; rst clears to RUN, fault=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding, constants and control-vector helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int          REG_IDX_W       = 5;
    localparam int          WAIT_W          = 8;
    localparam int          STALL_W         = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_out_t;

    // A memory stall freezes every stage and pushes a bubble into WB so nothing retires twice.
    localparam ctrl_out_t CTRL_NONE     = 8'b00000_000;
    localparam ctrl_out_t CTRL_RUN      = 8'b11111_000;
    localparam ctrl_out_t CTRL_MEM_WAIT = 8'b00000_001;
    localparam ctrl_out_t CTRL_BRANCH   = 8'b11111_110;
    localparam ctrl_out_t CTRL_LOAD_USE = 8'b00111_010;

    // Control vector for a cycle with no outstanding memory stall; a taken branch squashes the load-use victim anyway.
    function automatic ctrl_out_t run_decode(input logic branch_taken, input logic load_use);
        if (branch_taken)
            return CTRL_BRANCH;
        else if (load_use)
            return CTRL_LOAD_USE;
        else
            return CTRL_RUN;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator between the ID and EX stages
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_uses_rs2,
    input  logic [REG_IDX_W-1:0] i_ex_rd,
    input  logic                 i_ex_memread,
    output logic                 o_load_use
);

    logic w_rd_nonzero;
    logic w_hit_rs1;
    logic w_hit_rs2;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_hit_rs1    = (i_ex_rd == i_id_rs1);
    assign w_hit_rs2    = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);
    assign o_load_use   = i_ex_memread & w_rd_nonzero & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline stall/flush controller with memory-wait timeout and stall counter
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_memread,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 dmem_ack,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
    output logic                 fault,
    output logic [STALL_W-1:0]   stall_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

    ctrl_state_t        r_state;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic [STALL_W-1:0] r_stall_cnt;

    logic               w_load_use;
    logic               w_mem_stall;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               w_timeout_hit;
    ctrl_out_t          w_ctrl;

    hazard_detect u_hazard_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_rd       (ex_rd),
        .i_ex_memread  (ex_memread),
        .o_load_use    (w_load_use)
    );

    assign w_mem_stall   = mem_req & ~dmem_ack;
    assign w_wait_next   = r_wait_cnt + WAIT_W'(1);
    // The wait counter holds the number of completed wait cycles, so the TIMEOUT-th one trips the fault.
    assign w_timeout_hit = (w_wait_next == TIMEOUT_CNT);

    always_comb begin
        w_ctrl = CTRL_NONE;
        if (!rst) begin
            case (r_state)
                ST_RUN:      w_ctrl = w_mem_stall ? CTRL_MEM_WAIT
                                                  : run_decode(ex_branch_taken, w_load_use);
                ST_MEM_WAIT: w_ctrl = dmem_ack ? run_decode(ex_branch_taken, w_load_use)
                                               : CTRL_MEM_WAIT;
                default:     w_ctrl = CTRL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cnt != {STALL_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);

            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_wait_next;
                        if (w_timeout_hit)
                            r_state <= ST_FAULT;
                    end
                end
                ST_FAULT: r_state <= ST_FAULT;
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign pc_en       = w_ctrl.pc_en;
    assign ifid_en     = w_ctrl.ifid_en;
    assign idex_en     = w_ctrl.idex_en;
    assign exmem_en    = w_ctrl.exmem_en;
    assign memwb_en    = w_ctrl.memwb_en;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign memwb_flush = w_ctrl.memwb_flush;
    assign fault       = (r_state == ST_FAULT);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    // Expected control vectors {pc,ifid,idex,exmem,memwb enables, ifid,idex,memwb flushes}
    localparam logic [7:0] E_NONE = 8'b00000_000;
    localparam logic [7:0] E_RUN  = 8'b11111_000;
    localparam logic [7:0] E_MEM  = 8'b00000_001;
    localparam logic [7:0] E_BR   = 8'b11111_110;
    localparam logic [7:0] E_LU   = 8'b00111_010;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memread;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        dmem_ack;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic        fault;
    logic [15:0] stall_cnt;

    int n_cmp;
    int n_err;

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_flush     (memwb_flush),
        .fault           (fault),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [7:0] exp);
        chk(tag, {8'h00, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush}, {8'h00, exp});
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk_ctrl("reset_ctrl_zero", E_NONE);
        chk("reset_fault", {15'd0, fault}, 16'd0);
        chk("reset_stall_cnt", stall_cnt, 16'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctrl("run_idle", E_RUN);

        // rs2 path and ex_rd=0 guard, all within one low phase
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd3; id_uses_rs2 = 1'b0;
        #1;
        chk_ctrl("rs2_unused_no_hazard", E_RUN);
        id_uses_rs2 = 1'b1;
        #1;
        chk_ctrl("rs2_load_use", E_LU);
        ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        chk_ctrl("rd_zero_no_stall", E_RUN);

        // single-cycle load-use on rs1
        @(negedge clk);
        clear_inputs();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #1;
        chk_ctrl("rs1_load_use", E_LU);
        @(negedge clk);
        clear_inputs();
        #1;
        chk_ctrl("after_load_use", E_RUN);
        chk("load_use_stall_cnt", stall_cnt, 16'd1);

        // taken branch wins over load-use, loses to memory stall
        @(negedge clk);
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; ex_branch_taken = 1'b1;
        #1;
        chk_ctrl("branch_over_load_use", E_BR);
        mem_req = 1'b1; dmem_ack = 1'b1;
        #1;
        chk_ctrl("branch_mem_acked", E_BR);
        dmem_ack = 1'b0;
        #1;
        chk_ctrl("mem_stall_over_branch", E_MEM);
        mem_req = 1'b0;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("branch_no_stall_cnt", stall_cnt, 16'd1);

        // memory stall: one RUN stall cycle plus three wait cycles, ack on the fifth
        pulse_reset();
        chk("reset_clears_stall_cnt", stall_cnt, 16'd0);
        @(negedge clk);
        mem_req = 1'b1; dmem_ack = 1'b0;
        #1;
        chk_ctrl("mem_run_stall", E_MEM);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_ctrl($sformatf("mem_wait_%0d", i), E_MEM);
            chk($sformatf("mem_wait_nofault_%0d", i), {15'd0, fault}, 16'd0);
        end
        @(negedge clk);
        dmem_ack = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk_ctrl("ack_cycle_branch", E_BR);
        ex_branch_taken = 1'b0;
        #1;
        chk_ctrl("ack_cycle_run", E_RUN);
        @(negedge clk);
        clear_inputs();
        #1;
        chk_ctrl("back_in_run", E_RUN);
        chk("mem_stall_cnt", stall_cnt, 16'd4);

        // reset in the middle of a wait returns to RUN
        @(negedge clk);
        mem_req = 1'b1;
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        chk_ctrl("in_wait_before_reset", E_MEM);
        pulse_reset();
        chk_ctrl("wait_reset_to_run", E_RUN);
        chk("wait_reset_stall_cnt", stall_cnt, 16'd0);

        // timeout: five stall cycles then sticky fault
        @(negedge clk);
        mem_req = 1'b1; dmem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_ctrl($sformatf("timeout_stall_%0d", i), E_MEM);
            chk($sformatf("timeout_nofault_%0d", i), {15'd0, fault}, 16'd0);
            @(negedge clk);
        end
        #1;
        chk("fault_set", {15'd0, fault}, 16'd1);
        chk_ctrl("fault_ctrl", E_NONE);
        chk("fault_stall_cnt", stall_cnt, 16'd5);
        mem_req = 1'b0; dmem_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("fault_sticky", {15'd0, fault}, 16'd1);
        chk_ctrl("fault_ignores_ack", E_NONE);
        chk("fault_stall_cnt_grows", stall_cnt, 16'd6);
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("fault_reset_fault", {15'd0, fault}, 16'd0);
        chk("fault_reset_stall_cnt", stall_cnt, 16'd0);
        chk_ctrl("fault_reset_ctrl", E_NONE);
        rst = 1'b0;
        #1;
        chk_ctrl("fault_reset_run", E_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
